// File: rtl/connection_reverse_lookup.sv
// connection_reverse_lookup: resolves a connection index {way, hash} back to
// the stored connection key and its active flag. The table is cleared by an
// init sweep after reset and then kept coherent by a mirrored update stream.

// Simple dual-port block RAM: port A writes, port B reads with a two-cycle
// registered read. A read and a write to the same address in one cycle
// return the old contents.
module dual_port_bram #(
  parameter int WIDTH      = 33,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_din,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] b_data_reg;
  logic [WIDTH-1:0] b_dout_reg;

  // Port A: write-only
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_din;
    end
  end

  // Port B first stage: array read (sees pre-write contents on collision)
  always_ff @(posedge clk) begin
    if (b_en) begin
      b_data_reg <= mem[b_addr];
    end
  end

  // Port B second stage: output register
  always_ff @(posedge clk) begin
    b_dout_reg <= b_data_reg;
  end

  assign b_dout = b_dout_reg;

endmodule

module connection_reverse_lookup #(
  parameter int KEY_WIDTH      = 32,
  parameter int WAYS           = 4,
  parameter int HASH_WIDTH     = 16,
  parameter int RESP_WIDTH     = HASH_WIDTH + $clog2(WAYS),
  parameter int DEPTH          = 1 << RESP_WIDTH,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s00_axis_rv_lookup_valid,
  input  logic [RESP_WIDTH-1:0] s00_axis_rv_lookup_index,
  output logic                  s00_axis_rv_lookup_ready,
  output logic                  m00_axis_rv_lookup_valid,
  input  logic                  m00_axis_rv_lookup_ready,
  output logic                  m00_axis_rv_lookup_hit,
  output logic [KEY_WIDTH-1:0]  m00_axis_rv_lookup_key,
  output logic [RESP_WIDTH-1:0] m00_axis_rv_lookup_index,
  input  logic                  s01_axis_upd_valid,
  input  logic [RESP_WIDTH-1:0] s01_axis_upd_index,
  input  logic [KEY_WIDTH-1:0]  s01_axis_upd_key,
  input  logic                  s01_axis_upd_activate,
  output logic                  s01_axis_upd_ready
);

  localparam int ENTRY_WIDTH = KEY_WIDTH + 1;
  localparam int PTR_WIDTH   = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  // Wide enough for fifo occupancy plus the two pipeline stages.
  localparam int CNT_WIDTH   = $clog2(OUT_FIFO_DEPTH + 1) + 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  state_t                state_reg, state_next;
  logic [RESP_WIDTH-1:0] sweep_reg, sweep_next;

  // Table port A
  logic                   bram_we;
  logic [RESP_WIDTH-1:0]  bram_waddr;
  logic [ENTRY_WIDTH-1:0] bram_wdata;
  logic [ENTRY_WIDTH-1:0] bram_rdata;

  // Handshakes
  logic                   lookup_accept;
  logic                   upd_accept;
  logic [ENTRY_WIDTH-1:0] upd_entry;
  logic                   bypass_hit;
  logic                   credit_ok;
  logic [CNT_WIDTH-1:0]   credit_used;

  // Lookup pipeline stages
  logic                   s1_valid_reg;
  logic [RESP_WIDTH-1:0]  s1_index_reg;
  logic                   s1_byp_reg;
  logic [ENTRY_WIDTH-1:0] s1_byp_data_reg;
  logic                   s2_valid_reg;
  logic [RESP_WIDTH-1:0]  s2_index_reg;
  logic                   s2_byp_reg;
  logic [ENTRY_WIDTH-1:0] s2_byp_data_reg;

  // Merge result
  logic [ENTRY_WIDTH-1:0] merged_entry;
  logic                   merged_hit;
  logic [KEY_WIDTH-1:0]   merged_key;

  // Output FIFO
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [PTR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_WIDTH-1:0]   fifo_count_reg, fifo_count_next;
  logic [OUT_FIFO_DEPTH-1:0]                 slot_hit;
  logic [OUT_FIFO_DEPTH-1:0][KEY_WIDTH-1:0]  slot_key;
  logic [OUT_FIFO_DEPTH-1:0][RESP_WIDTH-1:0] slot_index;
  logic                   out_valid;

  // ---------------------------------------------------------------------
  // Handshake and hazard terms
  // ---------------------------------------------------------------------
  // Every lookup in a pipeline stage or the FIFO holds one FIFO credit, so
  // accepting only while credits remain means pushes can never overflow.
  assign credit_used   = fifo_count_reg
                       + CNT_WIDTH'(s1_valid_reg)
                       + CNT_WIDTH'(s2_valid_reg);
  assign credit_ok     = credit_used < CNT_WIDTH'(OUT_FIFO_DEPTH);

  assign lookup_accept = s00_axis_rv_lookup_valid && s00_axis_rv_lookup_ready;
  assign upd_accept    = s01_axis_upd_valid && s01_axis_upd_ready;

  // A cleared entry stores key 0 as well as valid 0.
  assign upd_entry     = {s01_axis_upd_activate,
                          s01_axis_upd_activate ? s01_axis_upd_key : {KEY_WIDTH{1'b0}}};

  // The BRAM read of a lookup happens in the same edge as a colliding write
  // and returns the old value, so the new entry is captured on the side.
  assign bypass_hit    = upd_accept && lookup_accept
                       && (s01_axis_upd_index == s00_axis_rv_lookup_index);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State and sweep counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  // Next state, init sweep writes and readiness
  always_comb begin
    state_next               = state_reg;
    sweep_next               = sweep_reg;
    bram_we                  = 1'b0;
    bram_waddr               = s01_axis_upd_index;
    bram_wdata               = upd_entry;
    s00_axis_rv_lookup_ready = 1'b0;
    s01_axis_upd_ready       = 1'b0;
    case (state_reg)
      INIT: begin
        bram_we    = 1'b1;
        bram_waddr = sweep_reg;
        bram_wdata = '0;
        if (sweep_reg == RESP_WIDTH'(DEPTH - 1)) begin
          state_next = RUN;
        end else begin
          sweep_next = sweep_reg + 1'b1;
        end
      end
      RUN: begin
        s01_axis_upd_ready       = 1'b1;
        s00_axis_rv_lookup_ready = credit_ok;
        bram_we                  = s01_axis_upd_valid;
      end
      default: begin
        state_next = INIT;
        sweep_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------
  dual_port_bram #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (RESP_WIDTH)
  ) u_table (
    .clk    (clk),
    .a_we   (bram_we),
    .a_addr (bram_waddr),
    .a_din  (bram_wdata),
    .b_en   (lookup_accept),
    .b_addr (s00_axis_rv_lookup_index),
    .b_dout (bram_rdata)
  );

  // ---------------------------------------------------------------------
  // Lookup pipeline
  // ---------------------------------------------------------------------
  // Stage valid bits; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= lookup_accept;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // Stage payload: request index plus any same-cycle update capture
  always_ff @(posedge clk) begin
    s1_index_reg    <= s00_axis_rv_lookup_index;
    s1_byp_reg      <= bypass_hit;
    s1_byp_data_reg <= upd_entry;
    s2_index_reg    <= s1_index_reg;
    s2_byp_reg      <= s1_byp_reg;
    s2_byp_data_reg <= s1_byp_data_reg;
  end

  assign merged_entry = s2_byp_reg ? s2_byp_data_reg : bram_rdata;
  assign merged_hit   = merged_entry[KEY_WIDTH];
  assign merged_key   = merged_hit ? merged_entry[KEY_WIDTH-1:0] : {KEY_WIDTH{1'b0}};

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  assign out_valid = (fifo_count_reg != '0);
  assign fifo_push = s2_valid_reg;
  assign fifo_pop  = out_valid && m00_axis_rv_lookup_ready;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    fifo_count_next = fifo_count_reg;
    if (fifo_push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_WIDTH'(OUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_WIDTH'(OUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
      2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      fifo_count_reg <= fifo_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUT_FIFO_DEPTH; gi++) begin : g_slot
      logic                  hit_reg;
      logic [KEY_WIDTH-1:0]  key_reg;
      logic [RESP_WIDTH-1:0] index_reg;

      // Capture the merged response when this slot is the write target
      always_ff @(posedge clk) begin
        if (fifo_push && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
          hit_reg   <= merged_hit;
          key_reg   <= merged_key;
          index_reg <= s2_index_reg;
        end
      end

      assign slot_hit[gi]   = hit_reg;
      assign slot_key[gi]   = key_reg;
      assign slot_index[gi] = index_reg;
    end
  endgenerate

  // Head of FIFO drives the response; fields read as zero while empty.
  assign m00_axis_rv_lookup_valid = out_valid;
  assign m00_axis_rv_lookup_hit   = out_valid && slot_hit[rd_ptr_reg];
  assign m00_axis_rv_lookup_key   = out_valid ? slot_key[rd_ptr_reg]   : {KEY_WIDTH{1'b0}};
  assign m00_axis_rv_lookup_index = out_valid ? slot_index[rd_ptr_reg] : {RESP_WIDTH{1'b0}};

endmodule

// File: tb/tb_connection_reverse_lookup.sv
// Testbench for connection_reverse_lookup (HASH_WIDTH=4, WAYS=2: 32 entries).
// A table model plus an expected-response queue is checked every cycle;
// directed scenarios pin the model with literal expectations.
module tb_connection_reverse_lookup;

  localparam int KW = 32;
  localparam int RW = 5;
  localparam int NE = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lk_valid = 1'b0;
  logic [RW-1:0] lk_index = '0;
  logic          lk_ready;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_hit;
  logic [KW-1:0] m_key;
  logic [RW-1:0] m_index;
  logic          upd_valid = 1'b0;
  logic [RW-1:0] upd_index = '0;
  logic [KW-1:0] upd_key = '0;
  logic          upd_act = 1'b0;
  logic          upd_ready;

  connection_reverse_lookup #(
    .KEY_WIDTH      (KW),
    .WAYS           (2),
    .HASH_WIDTH     (4),
    .OUT_FIFO_DEPTH (FD)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s00_axis_rv_lookup_valid (lk_valid),
    .s00_axis_rv_lookup_index (lk_index),
    .s00_axis_rv_lookup_ready (lk_ready),
    .m00_axis_rv_lookup_valid (m_valid),
    .m00_axis_rv_lookup_ready (m_ready),
    .m00_axis_rv_lookup_hit   (m_hit),
    .m00_axis_rv_lookup_key   (m_key),
    .m00_axis_rv_lookup_index (m_index),
    .s01_axis_upd_valid       (upd_valid),
    .s01_axis_upd_index       (upd_index),
    .s01_axis_upd_key         (upd_key),
    .s01_axis_upd_activate    (upd_act),
    .s01_axis_upd_ready       (upd_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RW-1:0] idx;
    logic          hit;
    logic [KW-1:0] key;
    int            acc;
    int            out;
  } rsp_t;

  // Model: table contents, expected responses in order, observed responses.
  logic          mv [NE];
  logic [KW-1:0] mk [NE];
  rsp_t          exp_q[$];
  rsp_t          rsp_log[$];
  int            init_cnt = 0;
  int            last_pop = -100;
  logic          mon_run;
  logic          mon_exp_valid;
  int            mon_avail;
  rsp_t          mon_r;

  initial begin
    for (int i = 0; i < NE; i++) begin
      mv[i] = 1'b0;
      mk[i] = '0;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NE; i++) begin
        mv[i] = 1'b0;
        mk[i] = '0;
      end
      init_cnt = 0;
      last_pop = -100;
    end else begin
      mon_run = (init_cnt >= NE);
      check("s00_ready", 64'(lk_ready), 64'(mon_run && (exp_q.size() < FD)));
      check("s01_ready", 64'(upd_ready), 64'(mon_run));
      mon_exp_valid = 1'b0;
      if (exp_q.size() > 0) begin
        mon_avail = exp_q[0].acc + 3;
        if (last_pop + 1 > mon_avail) mon_avail = last_pop + 1;
        mon_exp_valid = (cyc >= mon_avail);
      end
      check("m00_valid", 64'(m_valid), 64'(mon_exp_valid));
      if (m_valid && exp_q.size() > 0) begin
        check("m00_index", 64'(m_index), 64'(exp_q[0].idx));
        check("m00_hit", 64'(m_hit), 64'(exp_q[0].hit));
        check("m00_key", 64'(m_key), 64'(exp_q[0].key));
        if (m_ready) begin
          mon_r     = exp_q.pop_front();
          mon_r.idx = m_index;
          mon_r.hit = m_hit;
          mon_r.key = m_key;
          mon_r.out = cyc;
          rsp_log.push_back(mon_r);
          last_pop  = cyc;
        end
      end
      // updates in this cycle are visible to a lookup in this same cycle
      if (upd_valid && upd_ready) begin
        mv[upd_index] = upd_act;
        mk[upd_index] = upd_act ? upd_key : '0;
      end
      if (lk_valid && lk_ready) begin
        mon_r.idx = lk_index;
        mon_r.hit = mv[lk_index];
        mon_r.key = mv[lk_index] ? mk[lk_index] : '0;
        mon_r.acc = cyc;
        mon_r.out = 0;
        exp_q.push_back(mon_r);
      end
      if (init_cnt < 100000) init_cnt++;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (drive just after posedge)
  // ---------------------------------------------------------------------
  task automatic lookup(input logic [RW-1:0] idx);
    int n;
    lk_valid = 1'b1;
    lk_index = idx;
    n = 0;
    @(negedge clk);
    while (!lk_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!lk_ready) check("lookup_accept_timeout", 64'(lk_ready), 64'd1);
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [RW-1:0] idx, input logic [KW-1:0] key, input logic act);
    int n;
    upd_valid = 1'b1;
    upd_index = idx;
    upd_key   = key;
    upd_act   = act;
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!upd_ready) check("update_accept_timeout", 64'(upd_ready), 64'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_log(input int want, input int budget);
    int n;
    n = 0;
    while (rsp_log.size() < want && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (rsp_log.size() < want) check("response_timeout", 64'(rsp_log.size()), 64'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name, input int i, input logic [RW-1:0] idx,
                           input logic hit, input logic [KW-1:0] key);
    if (i < rsp_log.size()) begin
      check({name, "_index"}, 64'(rsp_log[i].idx), 64'(idx));
      check({name, "_hit"}, 64'(rsp_log[i].hit), 64'(hit));
      check({name, "_key"}, 64'(rsp_log[i].key), 64'(key));
    end else begin
      check({name, "_missing"}, 64'(rsp_log.size()), 64'(i + 1));
    end
  endtask

  // Count not-ready cycles from the current negedge (first post-reset cycle)
  task automatic measure_init(input string name);
    int n;
    n = 0;
    while (!lk_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'd32);
    check({name, "_upd_ready"}, 64'(upd_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------
  initial begin
    int i;
    int stalls;
    logic [63:0] snap;

    // Reset then idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_m00_valid", 64'(m_valid), 64'd0);
    check("rst_m00_hit", 64'(m_hit), 64'd0);
    check("rst_m00_key", 64'(m_key), 64'd0);
    check("rst_m00_index", 64'(m_index), 64'd0);
    check("rst_s00_ready", 64'(lk_ready), 64'd0);
    check("rst_s01_ready", 64'(upd_ready), 64'd0);
    measure_init("init_len");
    @(posedge clk);
    #1;

    // Lookup of a never-written entry, latency 3
    rsp_log.delete();
    lookup(5'd5);
    wait_log(1, 50);
    check_rsp("idle5", 0, 5'd5, 1'b0, 32'h0);
    if (rsp_log.size() > 0) check("idle5_latency", 64'(rsp_log[0].out - rsp_log[0].acc), 64'd3);

    // Activate then deactivate 0x13
    rsp_log.delete();
    update(5'h13, 32'hDEADBEEF, 1'b1);
    lookup(5'h13);
    update(5'h13, 32'h12345678, 1'b0);
    lookup(5'h13);
    wait_log(2, 50);
    check_rsp("set13", 0, 5'h13, 1'b1, 32'hDEADBEEF);
    check_rsp("clr13", 1, 5'h13, 1'b0, 32'h0);

    // Lookup one cycle before an update, then lookup in the same cycle
    rsp_log.delete();
    lookup(5'h07);
    upd_valid = 1'b1;
    upd_index = 5'h07;
    upd_key   = 32'h0A000001;
    upd_act   = 1'b1;
    lk_valid  = 1'b1;
    lk_index  = 5'h07;
    @(negedge clk);
    check("same_cycle_accept", 64'({lk_ready, upd_ready}), 64'd3);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    lk_valid  = 1'b0;
    wait_log(2, 50);
    check_rsp("before07", 0, 5'h07, 1'b0, 32'h0);
    check_rsp("same07", 1, 5'h07, 1'b1, 32'h0A000001);

    // Backpressure: 6 offered, 4 credits
    rsp_log.delete();
    m_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 10; c++) begin
      lk_valid = (i < 6);
      lk_index = RW'(i);
      @(negedge clk);
      if (lk_valid && lk_ready) i++;
      @(posedge clk);
      #1;
    end
    check("stall_accepted", 64'(i), 64'd4);
    check("stall_s00_ready", 64'(lk_ready), 64'd0);
    snap = {30'b0, m_valid, m_hit, m_key};
    check("stall_head_index", 64'(m_index), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("stall_hold", {30'b0, m_valid, m_hit, m_key}, snap);
    check("stall_hold_index", 64'(m_index), 64'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 30 && i < 6; c++) begin
      lk_valid = 1'b1;
      lk_index = RW'(i);
      @(negedge clk);
      if (lk_ready) i++;
      @(posedge clk);
      #1;
    end
    lk_valid = 1'b0;
    wait_log(6, 60);
    check("stall_count", 64'(rsp_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < rsp_log.size(); k++) begin
      check("stall_order", 64'(rsp_log[k].idx), 64'(k));
    end

    // Streaming 20 lookups
    rsp_log.delete();
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      lk_valid = 1'b1;
      lk_index = RW'(k);
      @(negedge clk);
      if (!lk_ready) stalls++;
      @(posedge clk);
      #1;
    end
    lk_valid = 1'b0;
    check("stream_stalls", 64'(stalls), 64'd0);
    wait_log(20, 80);
    for (int k = 0; k < 20 && k < rsp_log.size(); k++) begin
      check("stream_index", 64'(rsp_log[k].idx), 64'(k));
      check("stream_latency", 64'(rsp_log[k].out - rsp_log[k].acc), 64'd3);
    end
    if (rsp_log.size() >= 20) check("stream_rate", 64'(rsp_log[19].out - rsp_log[0].out), 64'd19);

    // Reset with two lookups in flight
    update(5'h13, 32'hCAFEF00D, 1'b1);
    rsp_log.delete();
    lookup(5'h13);
    lookup(5'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m00_valid", 64'(m_valid), 64'd0);
    measure_init("midrst_init_len");
    @(posedge clk);
    #1;
    check("midrst_dropped", 64'(rsp_log.size()), 64'd0);
    lookup(5'h13);
    wait_log(1, 50);
    check_rsp("midrst13", 0, 5'h13, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", checks - fails, checks);
    $fatal(1);
  end

endmodule

// File: doc/connection_reverse_lookup.md
Name: connection_reverse_lookup

Overview:
Reverse connection table. It maps a connection index {way, hash}, as produced by the forward lookup, back to the stored connection key and its active flag. It sits on the TX path: a payload tagged with a connection index is resolved to its key (destination tuple) before header build. Its contents are kept coherent by an update stream that mirrors every activate/deactivate the control path commits.

Parameters:
KEY_WIDTH, 32, width of the stored connection key
WAYS, 4, associativity of the forward table; way field width is $clog2(WAYS)
HASH_WIDTH, 16, width of the hash/set field of the index
RESP_WIDTH, HASH_WIDTH+$clog2(WAYS), index width; index = {way, hash}, hash in the LSBs
DEPTH, 1<<RESP_WIDTH, number of table entries
OUT_FIFO_DEPTH, 4, output FIFO entries; also the maximum number of outstanding lookups

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s00_axis_rv_lookup_valid  in  1  lookup request valid
s00_axis_rv_lookup_index  in  RESP_WIDTH  index to resolve
s00_axis_rv_lookup_ready  out  1  lookup accepted when valid&&ready
m00_axis_rv_lookup_valid  out  1  response valid
m00_axis_rv_lookup_ready  in  1  downstream ready
m00_axis_rv_lookup_hit  out  1  entry is active
m00_axis_rv_lookup_key  out  KEY_WIDTH  stored key; 0 when hit=0
m00_axis_rv_lookup_index  out  RESP_WIDTH  echo of the request index
s01_axis_upd_valid  in  1  table update valid
s01_axis_upd_index  in  RESP_WIDTH  entry to write
s01_axis_upd_key  in  KEY_WIDTH  key to store
s01_axis_upd_activate  in  1  1 = set entry active with key; 0 = clear entry (valid=0, key=0)
s01_axis_upd_ready  out  1  update accepted when valid&&ready

Behaviour:
- One clock, clk. Synchronous active-high reset, rst.
- Storage: one dual_port_bram of width KEY_WIDTH+1 {valid, key} and depth DEPTH.
  - Port A: write only (updates and init sweep).
  - Port B: read only (lookups).
  - Read latency is 2 cycles. Port B read-during-write to the same address returns the old data.
- FSM states: INIT, RUN.
  - rst forces INIT with sweep counter = 0.
  - INIT writes {0,0} to address = counter, one per cycle. After address DEPTH-1 is written, the FSM moves to RUN the following cycle.
  - INIT therefore lasts exactly DEPTH cycles after rst deasserts.
- Reset values:
  - m00_axis_rv_lookup_valid = 0, hit = 0, key = 0, index = 0.
  - s00_axis_rv_lookup_ready = 0, s01_axis_upd_ready = 0.
  - Output FIFO empty; in-flight count = 0.
- Readiness during each state:
  - In INIT, both ready outputs are 0.
  - In RUN, s01_axis_upd_ready = 1 unconditionally.
  - In RUN, s00_axis_rv_lookup_ready = 1 iff (fifo_count + inflight_count) < OUT_FIFO_DEPTH.
  - Both ready outputs are registered, or derived only from registered state, with no combinational path from any input.
- Update handling: an update accepted in cycle t writes port A in cycle t. Readers observe it from cycle t+1.
- Lookup pipeline:
  - Accept in cycle t: the index drives port B address.
  - Stage 1 and stage 2 carry the index plus a bypass capture.
  - The BRAM data is merged at the end of cycle t+2 and pushed into the output FIFO.
  - m00 valid asserts at t+3 when the FIFO was empty.
- Same-cycle hazard:
  - A lookup accepted in cycle t must reflect every update accepted in cycles <= t, and no later update.
  - If an update is accepted in cycle t with upd_index == lookup index, capture {activate, activate ? key : 0} into the stage registers. That captured value replaces the BRAM data at merge time.
  - Updates at t-1 or earlier are already committed in the BRAM.
- Response rules:
  - hit = stored valid.
  - key = stored key if hit, else 0.
  - index echoes the request.
  - Responses come out in request order, with no drops and no duplicates.
  - Sustained throughput is 1 lookup/cycle while m00_axis_rv_lookup_ready = 1.
- Output handshake: while m00 valid && !ready, hit, key and index are held stable. The FIFO pops on valid&&ready.
- Boundary conditions:
  - Credit accounting prevents the FIFO from overflowing, even with m00 ready held low for any duration.
  - A simultaneous FIFO push and pop leaves the count unchanged.
  - Updates to the same index in consecutive cycles: the last one wins.
  - The index field is always in range, since DEPTH = 2^RESP_WIDTH.
- Reset mid-operation: rst in any cycle discards in-flight lookups and FIFO contents. m00 valid is 0 from the next cycle, and the INIT sweep restarts from address 0, so all entries read as inactive afterwards.

Test Plan:
(All scenarios use HASH_WIDTH=4, WAYS=2, so RESP_WIDTH=5 and DEPTH=32.)
- Reset then idle -> both ready outputs are 0 for exactly 32 cycles, then 1. A lookup of index 5 accepted at cycle t -> m00 valid at t+3 with hit=0, key=0, index=5.
- Update index 0x13, key 0xDEADBEEF, activate=1. Lookup 0x13 in the next cycle -> hit=1, key=0xDEADBEEF. Then update 0x13 with activate=0 and look it up again -> hit=0, key=0.
- Update 0x07 with key 0x0A000001, activate=1, in the same cycle as a lookup of 0x07 -> hit=1, key=0x0A000001. Lookup of 0x07 one cycle before that update -> hit=0.
- Hold m00 ready=0 and offer 6 back-to-back lookups of 0..5 -> exactly 4 are accepted and s00 ready drops. Outputs stay stable while stalled. Release ready -> all 6 return in order 0..5 with no gaps or duplicates.
- Streaming: m00 ready=1 and 20 consecutive lookups -> s00 ready stays 1 and one response is produced per cycle.
- Populate 0x13. Assert rst for 1 cycle with 2 lookups in flight -> no m00 valid from them, a 32-cycle INIT follows, and a lookup of 0x13 afterwards -> hit=0.
